feature_packer: RTL and testbench

FEATURE_PACKER -- requirements
Module: feature_packer

---
 rtl/feature_packer_pkg.sv | 26 ++
 rtl/frame_fifo2.sv | 73 +++++++
 rtl/feature_packer.sv | 111 +++++++++++
 tb/tb_feature_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_packer_pkg.sv
// Shared definitions for the feature packer.
// Supplies the default channel geometry (TOTAL_NUM_CHANNEL, CHANNEL_WIDTH)
// when no shared constants header has defined them, plus the frame
// assembly FSM state type used by feature_packer.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 2
`endif

package feature_packer_pkg;

  // FILL packs channels into the fill register; DISCARD drops the tail of an
  // over-long frame until its ch_last is seen.
  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_DISCARD = 1'b1
  } pack_state_t;

  // Width of a counter indexing n slots (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_fifo2.sv
// Two-entry valid/ready FIFO holding packed feature frames.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   write handshake; in_ready is registered (!full)
//   in_data             frame to write
//   out_valid/out_ready read handshake; out_valid is registered (!empty)
//   out_data            head entry, driven straight from a register
module frame_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, tail_q;
  logic         in_ready_q, out_valid_q;
  logic         push, pop;

  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

  // NOTE: every variable written in always_comb gets a default first so no
  // latch is inferred on the paths that do not assign it.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Flags are computed from the next occupancy so they are registered yet
  // exact; in_ready therefore has no combinational path from out_ready.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      // NOTE: the two data entries are reset too, because out_data is a
      // visible output that must read zero after reset.
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      count_q     <= count_d;
      in_ready_q  <= (count_d != 2'd2);
      out_valid_q <= (count_d != 2'd0);

      // Head loads the new frame when it becomes (or stays) the only entry,
      // otherwise it advances from the tail on a pop.
      if (push && (count_q == 2'd0 || (count_q == 2'd1 && pop)))
        head_q <= in_data;
      else if (pop && count_q == 2'd2)
        head_q <= tail_q;

      if (push && ((count_q == 2'd1 && !pop) || count_q == 2'd2))
        tail_q <= in_data;
    end
  end

endmodule

// File: rtl/feature_packer.sv
// Serial-to-parallel feature packer feeding hdc_sensor_fusion.
// Channels arrive one per ch_valid/ch_ready handshake and are packed MSB
// first (channel 0 in the top CH_W bits) into a fill register; a completed
// frame is pushed into a 2-entry FIFO whose head drives features_top.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   ch_valid/ch_ready         serial channel handshake (ch_ready registered)
//   ch_data, ch_last          channel value, end-of-frame marker
//   fout_valid/fout_ready     packed frame handshake (to fin_valid/fin_ready)
//   features_top              packed frame, NUM_CH*CH_W bits
//   frame_err                 one-cycle pulse on a short or long frame
//   frame_count               frames delivered, wraps modulo 2^CNT_W
module feature_packer
  import feature_packer_pkg::*;
#(
  parameter int NUM_CH = `TOTAL_NUM_CHANNEL,
  parameter int CH_W   = `CHANNEL_WIDTH,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ch_valid,
  output logic                   ch_ready,
  input  logic [CH_W-1:0]        ch_data,
  input  logic                   ch_last,
  output logic                   fout_valid,
  input  logic                   fout_ready,
  output logic [NUM_CH*CH_W-1:0] features_top,
  output logic                   frame_err,
  output logic [CNT_W-1:0]       frame_count
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam int FW    = NUM_CH * CH_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  pack_state_t      state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [FW-1:0]    fill_q, frame_d;
  logic             accept, last_slot, push, pop;

  assign accept    = ch_valid && ch_ready;
  assign last_slot = (cnt_q == LAST_IDX);
  assign push      = accept && (state_q == ST_FILL) && last_slot;
  assign pop       = fout_valid && fout_ready;

  // The pushed frame must include the channel accepted this very cycle, so
  // the FIFO input is the fill register with the current slot overlaid.
  always_comb begin
    frame_d = fill_q;
    frame_d[(NUM_CH - 1 - int'(cnt_q)) * CH_W +: CH_W] = ch_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      fill_q      <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_err <= 1'b0;
      if (pop)
        frame_count <= frame_count + CNT_W'(1);

      if (accept) begin
        case (state_q)
          ST_FILL: begin
            fill_q <= frame_d;
            if (last_slot) begin
              // Full frame pushed either way; missing ch_last means the
              // rest of this frame must be dropped.
              cnt_q <= '0;
              if (!ch_last) begin
                frame_err <= 1'b1;
                state_q   <= ST_DISCARD;
              end
            end else if (ch_last) begin
              // Short frame: the partial contents are simply abandoned.
              frame_err <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
          ST_DISCARD: begin
            if (ch_last) begin
              state_q <= ST_FILL;
              cnt_q   <= '0;
            end
          end
          default: state_q <= ST_FILL;
        endcase
      end
    end
  end

  frame_fifo2 #(
    .W (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (ch_ready),
    .in_data   (frame_d),
    .out_valid (fout_valid),
    .out_ready (fout_ready),
    .out_data  (features_top)
  );

endmodule

// File: tb/tb_feature_packer.sv
// Self-checking bench for feature_packer with NUM_CH=4, CH_W=2.
// A reference model of the framing rules pushes expected frames into a
// scoreboard queue as channels are accepted; a monitor pops and compares
// each frame the DUT delivers.
module tb_feature_packer;
  import feature_packer_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 16;
  localparam int FW     = NUM_CH * CH_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             ch_valid;
  logic             ch_ready;
  logic [CH_W-1:0]  ch_data;
  logic             ch_last;
  logic             fout_valid;
  logic             fout_ready;
  logic [FW-1:0]    features_top;
  logic             frame_err;
  logic [CNT_W-1:0] frame_count;

  feature_packer #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_valid     (ch_valid),
    .ch_ready     (ch_ready),
    .ch_data      (ch_data),
    .ch_last      (ch_last),
    .fout_valid   (fout_valid),
    .fout_ready   (fout_ready),
    .features_top (features_top),
    .frame_err    (frame_err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard and reference model of the framing rules.
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] m_fill;
  int            m_cnt     = 0;
  bit            m_discard = 1'b0;
  int            m_err     = 0;
  int            err_seen  = 0;

  task automatic model_accept(input logic [CH_W-1:0] d, input logic l);
    if (!m_discard) begin
      m_fill[(NUM_CH - 1 - m_cnt) * CH_W +: CH_W] = d;
      if (m_cnt == NUM_CH - 1) begin
        exp_q.push_back(m_fill);
        m_cnt = 0;
        if (!l) begin
          m_err++;
          m_discard = 1'b1;
        end
      end else if (l) begin
        m_err++;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (l) begin
      m_discard = 1'b0;
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, i.e. the values
  // that will be seen at the next rising edge.
  logic          prev_stall = 1'b0;
  logic [FW-1:0] prev_data;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(fout_valid), 32'd1);
        check("hold_data", 32'(features_top), 32'(prev_data));
      end
      if (fout_valid && fout_ready) begin
        if (exp_q.size() == 0)
          check("unexpected_frame", 32'(features_top), 32'hFFFF_FFFF);
        else
          check("frame", 32'(features_top), 32'(exp_q.pop_front()));
      end
      if (frame_err) err_seen++;
      prev_stall = fout_valid && !fout_ready;
      prev_data  = features_top;
    end
  end

  // Drive one channel starting at a falling edge; returns on the falling
  // edge after the accepting rising edge.
  task automatic send_ch(input logic [CH_W-1:0] d, input logic l);
    int n = 0;
    ch_valid = 1'b1;
    ch_data  = d;
    ch_last  = l;
    while (!ch_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check("ch_ready_timeout", 32'(n), 32'd0);
    end else begin
      model_accept(d, l);
      @(negedge clk);
    end
    ch_valid = 1'b0;
    ch_data  = 'x;
    ch_last  = 1'bx;
  endtask

  task automatic send_frame(input logic [FW-1:0] f);
    for (int k = 0; k < NUM_CH; k++)
      send_ch(f[(NUM_CH - 1 - k) * CH_W +: CH_W], k == NUM_CH - 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || fout_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fout_valid"}, 32'(fout_valid), 32'd0);
    check({tag, "_ch_ready"}, 32'(ch_ready), 32'd0);
    check({tag, "_features"}, 32'(features_top), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    ch_valid   = 1'b0;
    ch_data    = '0;
    ch_last    = 1'b0;
    fout_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(ch_ready), 32'd1);

    // Basic frame: 3,2,1,0 -> 11_10_01_00, visible one cycle after last accept.
    send_frame(8'b11_10_01_00);
    check("basic_valid", 32'(fout_valid), 32'd1);
    check("basic_data", 32'(features_top), 32'hE4);
    wait_drain();
    check("basic_count", 32'(frame_count), 32'd1);
    check("basic_err", 32'(err_seen), 32'(m_err));

    // Backpressure: three frames against a stalled consumer.
    fout_ready = 1'b0;
    fork
      begin
        send_frame(8'b00_01_10_11);
        send_frame(8'b11_10_01_00);
        send_frame(8'b10_01_11_00);
      end
      begin
        repeat (20) @(negedge clk);
        check("bp_ch_ready", 32'(ch_ready), 32'd0);
        check("bp_valid", 32'(fout_valid), 32'd1);
        check("bp_head", 32'(features_top), 32'h1B);
        check("bp_count", 32'(frame_count), 32'd1);
        fout_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_final_count", 32'(frame_count), 32'd4);

    // Short frame: 1,1 with ch_last, then a good frame.
    send_ch(2'd1, 1'b0);
    send_ch(2'd1, 1'b1);
    send_frame(8'b00_11_11_01);
    wait_drain();
    check("short_err", 32'(err_seen), 32'd1);
    check("short_count", 32'(frame_count), 32'd5);

    // Long frame: 2,2,1,1,3 (last on 5th), then a good frame.
    send_ch(2'd2, 1'b0);
    send_ch(2'd2, 1'b0);
    send_ch(2'd1, 1'b0);
    send_ch(2'd1, 1'b0);
    send_ch(2'd3, 1'b1);
    send_frame(8'b11_00_00_11);
    wait_drain();
    check("long_err", 32'(err_seen), 32'd2);
    check("long_count", 32'(frame_count), 32'd7);
    check("model_err", 32'(err_seen), 32'(m_err));

    // Simultaneous push and pop with one frame buffered.
    fout_ready = 1'b0;
    send_frame(8'b01_01_10_10);
    send_ch(2'd3, 1'b0);
    send_ch(2'd3, 1'b0);
    send_ch(2'd0, 1'b0);
    fout_ready = 1'b1;
    send_ch(2'd0, 1'b1);
    fout_ready = 1'b0;
    check("pp_valid", 32'(fout_valid), 32'd1);
    check("pp_head", 32'(features_top), 32'hF0);
    check("pp_ch_ready", 32'(ch_ready), 32'd1);
    send_frame(8'b10_11_00_01);
    check("pp_full", 32'(ch_ready), 32'd0);
    check("pp_head_kept", 32'(features_top), 32'hF0);
    fout_ready = 1'b1;
    wait_drain();
    check("pp_count", 32'(frame_count), 32'd10);

    // Reset mid-frame with a buffered frame waiting.
    fout_ready = 1'b0;
    send_frame(8'b11_11_11_11);
    send_ch(2'd2, 1'b0);
    send_ch(2'd3, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    m_cnt     = 0;
    m_discard = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    fout_ready = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(ch_ready), 32'd1);
    send_frame(8'b01_10_11_00);
    check("midrst_data", 32'(features_top), 32'h6C);
    wait_drain();
    check("midrst_count", 32'(frame_count), 32'd1);
    check("final_err", 32'(err_seen), 32'(m_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
